reaction_timer_mp: RTL and testbench



---
 rtl/reaction_timer_mp.sv | 213 +++++++++++++++++++++
 tb/tb_reaction_timer_mp.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction timer: random PREP delay, BCD ms timing, false-start/timeout detection, best-time tracking.
// All outputs registered; state moves one clk after its cause. No backpressure: inputs are one-cycle pulses.
module reaction_timer_mp #(
  parameter int PLAYERS    = 2,
  parameter int DIGITS     = 4,
  parameter int TICK_DIV   = 100000,
  parameter int TIMEOUT_MS = 9999,
  parameter int FAIL_MS    = 3000,
  parameter int RESULT_MS  = 10000,
  parameter int SHOW_MS    = 3000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PLAYERS-1:0]    stop,
  input  logic                  show_best,
  input  logic [12:0]           rand_delay,
  output logic [2:0]            state,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic [1:0]            disp_player,
  output logic [1:0]            fault,
  output logic                  best_valid,
  output logic [15:0]           led
);

  localparam int BW   = 4 * DIGITS;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int M1   = (FAIL_MS > RESULT_MS) ? FAIL_MS : RESULT_MS;
  localparam int M2   = (M1 > SHOW_MS) ? M1 : SHOW_MS;
  localparam int MAXD = (M2 > 8191) ? M2 : 8191;
  localparam int CW   = $clog2(MAXD + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_PREP   = 3'b001,
    S_TEST   = 3'b011,
    S_RESULT = 3'b010,
    S_FAIL   = 3'b100,
    S_BEST   = 3'b101,
    S_NULL   = 3'b110
  } state_t;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    int r;
    r = v;
    to_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic c;
    c = 1'b1;
    bcd_inc = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
  endfunction

  // Lowest-numbered pressed button wins simultaneous presses.
  function automatic logic [1:0] low_idx(input logic [PLAYERS-1:0] s);
    low_idx = 2'd0;
    for (int i = PLAYERS - 1; i >= 0; i--) begin
      if (s[i]) low_idx = 2'(i);
    end
  endfunction

  localparam logic [BW-1:0] TIMEOUT_BCD = to_bcd(TIMEOUT_MS);

  state_t          cur, nxt;
  logic [PW-1:0]   presc, presc_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   elapsed, elapsed_n;
  logic [BW-1:0]   best, best_n;
  logic [1:0]      best_player, bp_n;
  logic [BW-1:0]   disp_n;
  logic [1:0]      dp_n, fault_n;
  logic            bv_n, entry, tick;
  logic [15:0]     led_n;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (!reset) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    tick      = (presc == PW'(TICK_DIV - 1));
    nxt       = cur;
    cnt_n     = cnt;
    elapsed_n = elapsed;
    disp_n    = disp_bcd;
    dp_n      = disp_player;
    fault_n   = fault;
    led_n     = led;
    best_n    = best;
    bp_n      = best_player;
    bv_n      = best_valid;

    case (cur)
      S_IDLE: begin
        if (start) begin
          nxt = S_PREP;
        end else if (show_best) begin
          nxt = best_valid ? S_BEST : S_NULL;
        end else if (tick) begin
          // cnt counts ms up to one 125 ms animation step
          if (cnt == CW'(124)) begin
            cnt_n = '0;
            led_n = (led == 16'hFFFF) ? 16'h0180 : (led | (led << 1) | (led >> 1));
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      S_PREP: begin
        if (|stop) begin
          nxt     = S_FAIL;
          fault_n = 2'b01;
          dp_n    = low_idx(stop);
        end else if (cnt == '0) begin
          nxt = S_TEST;
        end else if (tick) begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_TEST: begin
        if (|stop) begin
          nxt    = S_RESULT;
          disp_n = elapsed;
          dp_n   = low_idx(stop);
        end else if (elapsed == TIMEOUT_BCD) begin
          nxt     = S_FAIL;
          fault_n = 2'b10;
          dp_n    = 2'd0;
        end else if (tick) begin
          elapsed_n = bcd_inc(elapsed);
        end
      end
      S_RESULT: begin
        if (entry && (!best_valid || disp_bcd < best)) begin
          best_n = disp_bcd;
          bp_n   = disp_player;
          bv_n   = 1'b1;
        end
        if (show_best)          nxt = S_BEST;
        else if (cnt == '0)     nxt = S_IDLE;
        else if (tick)          cnt_n = cnt - CW'(1);
      end
      S_FAIL, S_BEST, S_NULL: begin
        if (cnt == '0)  nxt = S_IDLE;
        else if (tick)  cnt_n = cnt - CW'(1);
      end
      default: nxt = S_IDLE;
    endcase

    // Per-state setup applied on the transition edge
    if (nxt != cur) begin
      if (nxt != S_FAIL) fault_n = 2'b00;
      case (nxt)
        S_IDLE:   begin led_n = 16'h0180; cnt_n = '0; end
        S_PREP:   begin led_n = '0; cnt_n = CW'(rand_delay); end
        S_TEST:   begin led_n = 16'hFFFF; elapsed_n = '0; end
        S_RESULT: begin led_n = '0; cnt_n = CW'(RESULT_MS); end
        S_FAIL:   begin led_n = '0; cnt_n = CW'(FAIL_MS); end
        S_BEST:   begin led_n = '0; cnt_n = CW'(SHOW_MS); disp_n = best_n; dp_n = bp_n; end
        S_NULL:   begin led_n = '0; cnt_n = CW'(SHOW_MS); disp_n = '1; dp_n = 2'd0; end
        default:  ;
      endcase
    end

    presc_n = ((nxt != cur) || tick) ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc       <= '0;
      cnt         <= '0;
      elapsed     <= '0;
      best        <= {DIGITS{4'h9}};
      best_player <= 2'd0;
      best_valid  <= 1'b0;
      disp_bcd    <= '0;
      disp_player <= 2'd0;
      fault       <= 2'b00;
      led         <= 16'h0180;
      entry       <= 1'b0;
    end else begin
      presc       <= presc_n;
      cnt         <= cnt_n;
      elapsed     <= elapsed_n;
      best        <= best_n;
      best_player <= bp_n;
      best_valid  <= bv_n;
      disp_bcd    <= disp_n;
      disp_player <= dp_n;
      fault       <= fault_n;
      led         <= led_n;
      entry       <= (nxt != cur);
    end
  end

endmodule

// File: tb/tb_reaction_timer_mp.sv
// Scoreboard bench for reaction_timer_mp: driver queues expected state-change records, monitor checks them.
module tb_reaction_timer_mp;

  localparam logic [2:0] IDLE = 3'b000, PREP = 3'b001, TEST = 3'b011, RESULT = 3'b010,
                         FAILS = 3'b100, BEST = 3'b101, NUL = 3'b110;
  localparam logic [4:0] M_DISP = 5'd1, M_PL = 5'd2, M_FLT = 5'd4, M_BV = 5'd8, M_LED = 5'd16;
  localparam logic [4:0] M_ALL = 5'h1F;

  logic        clk = 1'b0;
  logic        reset, start, show_best;
  logic [1:0]  stop;
  logic [12:0] rand_delay;
  logic [2:0]  state;
  logic [15:0] disp_bcd;
  logic [1:0]  disp_player, fault;
  logic        best_valid;
  logic [15:0] led;

  reaction_timer_mp #(
    .PLAYERS(2), .DIGITS(4), .TICK_DIV(4), .TIMEOUT_MS(1200),
    .FAIL_MS(3), .RESULT_MS(5), .SHOW_MS(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .show_best(show_best),
    .rand_delay(rand_delay), .state(state), .disp_bcd(disp_bcd),
    .disp_player(disp_player), .fault(fault), .best_valid(best_valid), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] disp;
    logic [1:0]  pl;
    logic [1:0]  flt;
    logic        bv;
    logic [15:0] led;
    int          dt;
    logic [4:0]  m;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   tmo_cnt = 0, tmo_seen = 0;
  bit   snap = 1'b0, done = 1'b0;

  task automatic push(input logic [2:0] st, input logic [15:0] d, input logic [1:0] p,
                      input logic [1:0] f, input logic b, input logic [15:0] l,
                      input int dt, input logic [4:0] m);
    exp_t e;
    e.st = st; e.disp = d; e.pl = p; e.flt = f; e.bv = b; e.led = l; e.dt = dt; e.m = m;
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input int ev, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s event=%0d got=%h want=%h", nm, ev, act, exp);
    end
  endtask

  // Monitor: one record per state change (or snapshot request)
  initial begin
    exp_t        e;
    int          cyc, last_cyc, ev_n;
    logic [2:0]  prev_st;
    cyc = 0; last_cyc = 0; ev_n = 0; prev_st = IDLE;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (tmo_cnt != tmo_seen) begin
        checks++;
        errors++;
        tmo_seen++;
      end
      if (state !== prev_st || snap) begin
        ev_n++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event event=%0d got_state=%b want=none", ev_n, state);
        end else begin
          e = q.pop_front();
          cmp("state", ev_n, {13'd0, state}, {13'd0, e.st});
          if (e.m[0]) cmp("disp_bcd", ev_n, disp_bcd, e.disp);
          if (e.m[1]) cmp("disp_player", ev_n, {14'd0, disp_player}, {14'd0, e.pl});
          if (e.m[2]) cmp("fault", ev_n, {14'd0, fault}, {14'd0, e.flt});
          if (e.m[3]) cmp("best_valid", ev_n, {15'd0, best_valid}, {15'd0, e.bv});
          if (e.m[4]) cmp("led", ev_n, led, e.led);
          if (e.dt >= 0 && state !== prev_st)
            cmp("cycles_since_prev_state", ev_n, 16'(cyc - last_cyc), 16'(e.dt));
        end
        if (state !== prev_st) last_cyc = cyc;
        prev_st = state;
      end
      if (done) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL pending_expected got=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_state(input logic [2:0] s, input int limit, input string nm);
    int n;
    n = 0;
    while (state !== s && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (state !== s) begin
      $display("FAIL wait_%s got_state=%b want_state=%b", nm, state, s);
      tmo_cnt++;
    end
  endtask

  task automatic do_snap();
    @(negedge clk); snap = 1'b1;
    @(negedge clk); snap = 1'b0;
  endtask

  task automatic pulse_start(input logic [12:0] d);
    rand_delay = d; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop_after_test(input int k, input logic [1:0] sv);
    wait_state(TEST, 40000, "test");
    repeat (k) @(negedge clk);
    stop = sv;
    @(negedge clk); stop = 2'b00;
  endtask

  // Full round: TEST stop in cycle k after entry gives floor(k/4) ms at TICK_DIV=4.
  task automatic round_result(input logic [12:0] d, input int k, input logic [1:0] sv,
                              input logic [15:0] v, input logic [1:0] p,
                              input logic bv0, input logic bv1);
    push(PREP, 0, 0, 2'b00, bv0, 16'h0000, -1, M_FLT | M_BV | M_LED);
    push(TEST, 0, 0, 2'b00, bv0, 16'hFFFF, 4 * d + 1, M_BV | M_LED);
    push(RESULT, v, p, 2'b00, bv0, 16'h0000, k + 1, M_ALL);
    push(IDLE, v, p, 2'b00, bv1, 16'h0180, 21, M_ALL);
    pulse_start(d);
    pulse_stop_after_test(k, sv);
    wait_state(IDLE, 100, "idle_after_result");
  endtask

  task automatic show_check(input logic [2:0] st, input logic [15:0] d, input logic [1:0] p,
                            input logic b);
    push(st, d, p, 2'b00, b, 16'h0000, -1, M_DISP | M_PL | M_FLT | M_BV);
    push(IDLE, d, p, 2'b00, b, 16'h0180, 9, M_ALL);
    show_best = 1'b1;
    @(negedge clk); show_best = 1'b0;
    wait_state(st, 5, "show");
    wait_state(IDLE, 40, "idle_after_show");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; show_best = 1'b0; stop = 2'b00; rand_delay = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    push(IDLE, 16'h0000, 0, 2'b00, 1'b0, 16'h0180, -1, M_ALL);
    do_snap();
    repeat (600) @(negedge clk);
    push(IDLE, 0, 0, 2'b00, 1'b0, 16'h03C0, -1, M_LED);
    do_snap();

    show_check(NUL, 16'hFFFF, 2'd0, 1'b0);
    round_result(13'd5, 30, 2'b10, 16'h0007, 2'd1, 1'b0, 1'b1);
    show_check(BEST, 16'h0007, 2'd1, 1'b1);

    // False start in PREP
    push(PREP, 0, 0, 2'b00, 1'b1, 16'h0000, -1, M_FLT | M_BV | M_LED);
    push(FAILS, 0, 2'd0, 2'b01, 1'b1, 16'h0000, -1, M_PL | M_FLT | M_BV | M_LED);
    push(IDLE, 0, 0, 2'b00, 1'b1, 16'h0180, 13, M_BV | M_LED);
    pulse_start(13'd5);
    wait_state(PREP, 5, "prep");
    repeat (2) @(negedge clk);
    stop = 2'b01;
    @(negedge clk); stop = 2'b00;
    wait_state(FAILS, 5, "fail_false_start");
    wait_state(IDLE, 60, "idle_after_fail");
    show_check(BEST, 16'h0007, 2'd1, 1'b1);

    // Timeout at 1200 ms, zero PREP delay
    push(PREP, 0, 0, 2'b00, 1'b1, 16'h0000, -1, M_FLT | M_BV | M_LED);
    push(TEST, 0, 0, 2'b00, 1'b1, 16'hFFFF, 1, M_BV | M_LED);
    push(FAILS, 0, 0, 2'b10, 1'b1, 16'h0000, 4801, M_FLT | M_BV | M_LED);
    push(IDLE, 0, 0, 2'b00, 1'b1, 16'h0180, 13, M_BV | M_LED);
    pulse_start(13'd0);
    wait_state(TEST, 5, "test_zero_delay");
    wait_state(FAILS, 6000, "fail_timeout");
    wait_state(IDLE, 60, "idle_after_timeout");

    // Decimal carry 0999->1000, simultaneous stops credit player 0
    round_result(13'd1, 4001, 2'b11, 16'h1000, 2'd0, 1'b1, 1'b1);

    // Reset during TEST
    push(PREP, 0, 0, 2'b00, 1'b1, 16'h0000, -1, M_FLT | M_BV | M_LED);
    push(TEST, 0, 0, 2'b00, 1'b1, 16'hFFFF, 5, M_BV | M_LED);
    push(IDLE, 16'h0000, 0, 2'b00, 1'b0, 16'h0180, -1, M_ALL);
    pulse_start(13'd1);
    wait_state(TEST, 20, "test_before_reset");
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    wait_state(IDLE, 5, "idle_after_reset_test");

    // Reset during RESULT
    push(PREP, 0, 0, 2'b00, 1'b0, 16'h0000, -1, M_FLT | M_BV | M_LED);
    push(TEST, 0, 0, 2'b00, 1'b0, 16'hFFFF, 5, M_BV | M_LED);
    push(RESULT, 16'h0002, 2'd0, 2'b00, 1'b0, 16'h0000, 10, M_ALL);
    push(IDLE, 16'h0000, 0, 2'b00, 1'b0, 16'h0180, -1, M_ALL);
    pulse_start(13'd1);
    pulse_stop_after_test(9, 2'b01);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    wait_state(IDLE, 5, "idle_after_reset_result");

    // Best tracking: tie keeps older holder, strictly better replaces
    round_result(13'd3, 81, 2'b10, 16'h0020, 2'd1, 1'b0, 1'b1);
    show_check(BEST, 16'h0020, 2'd1, 1'b1);
    round_result(13'd2, 81, 2'b01, 16'h0020, 2'd0, 1'b1, 1'b1);
    show_check(BEST, 16'h0020, 2'd1, 1'b1);
    round_result(13'd4, 61, 2'b01, 16'h0015, 2'd0, 1'b1, 1'b1);
    show_check(BEST, 16'h0015, 2'd0, 1'b1);

    repeat (5) @(negedge clk);
    done = 1'b1;
  end

endmodule
